// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART command receiver.
// Holds the RX FSM state encoding and the baud divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Mid-bit sampling 8N1 receive engine.
// Synchronizer, framing FSM, bit/DIV counters and shift register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  logic                 s1;
  logic                 s2;
  logic [1:0]           warm;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bitn;
  logic [DATA_BITS-1:0] sh;

  wire top_cnt  = (cnt == CW'(DIV - 1));
  wire half_cnt = (cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= 1'b1;
      s2        <= 1'b1;
      warm      <= 2'd0;
      state     <= WAIT_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      s1        <= rx_in;
      s2        <= s1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      // s2 only reflects the pin once both flops have been clocked
      if (warm != 2'd2) warm <= warm + 2'd1;
      unique case (state)
        WAIT_IDLE: begin
          if (warm == 2'd2 && s2) state <= IDLE;
        end
        IDLE: begin
          if (!s2) begin
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (half_cnt) begin
            cnt   <= '0;
            bitn  <= '0;
            state <= s2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (top_cnt) begin
            cnt  <= '0;
            sh   <= {s2, sh[DATA_BITS-1:1]};
            bitn <= bitn + 3'd1;
            if (bitn == 3'(DATA_BITS - 1)) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (top_cnt) begin
            cnt <= '0;
            if (s2) begin
              data  <= sh;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: decodes received bytes into one-hot command
// pulses with an optional hold-off window and a dropped-command counter.
module uart_cmd_rx
  import uart_pkg::*;
#(
  parameter int                 CLK_FREQ       = 65_000_000,
  parameter int                 BAUD           = 115_200,
  parameter int                 N_CMD          = 4,
  parameter logic [N_CMD*8-1:0] CMD_CODES      = 32'h34_33_32_31,
  parameter int                 HOLDOFF_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic [N_CMD-1:0] cmd_pulse,
  output logic             frame_err,
  output logic [7:0]       drop_cnt
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int HW  =
    (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  if (DIV < 4) begin : g_bad_div
    $error("uart_cmd_rx: CLK_FREQ/BAUD must be at least 4");
  end
  if (N_CMD < 1 || N_CMD > 16) begin : g_bad_ncmd
    $error("uart_cmd_rx: N_CMD must be in 1..16");
  end

  logic [7:0]       data;
  logic             valid;
  logic             ferr;
  logic [N_CMD-1:0] hit;
  logic [HW-1:0]    hold;

  uart_rx_core #(
    .DIV(DIV)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_in    (rx_in),
    .data     (data),
    .valid    (valid),
    .frame_err(ferr)
  );

  // Scan high to low so the lowest matching index ends up as the winner
  always_comb begin
    hit = '0;
    for (int k = N_CMD - 1; k >= 0; k--) begin
      if (data == CMD_CODES[k*8 +: 8]) begin
        hit    = '0;
        hit[k] = 1'b1;
      end
    end
  end

  wire busy    = (hold != '0);
  wire matched = |hit;

  assign cmd_pulse  = (valid && !busy) ? hit : '0;
  assign byte_valid = valid;
  assign byte_data  = data;
  assign frame_err  = ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold     <= '0;
      drop_cnt <= '0;
    end else begin
      if (|cmd_pulse) begin
        hold <= HW'(HOLDOFF_CYCLES);
      end else if (busy) begin
        hold <= hold - 1'b1;
      end
      if (valid && matched && busy && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule
